// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit teaching CPU: opcodes, sizes, display constants
// and the immediate sign-extension helpers.
package mips_pkg;

  localparam int unsigned DMEM_DEPTH = 32;
  localparam int unsigned NREGS      = 4;
  localparam int unsigned DMEM_AW    = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_J   = 2'b11
  } opcode_e;

  // All segments off on an active-low display
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Fields of one instruction byte
  typedef struct packed {
    opcode_e    op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
  } instr_t;

  function automatic logic [7:0] sext2(input logic [1:0] v);
    return {{6{v[1]}}, v};
  endfunction

  function automatic logic [7:0] sext6(input logic [5:0] v);
    return {{2{v[5]}}, v};
  endfunction

endpackage

// File: rtl/mips_seg7_hex.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} 7-segment pattern.
module seg7_hex (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Pure lookup of the 16 hex glyphs
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/mips.sv
// Single-cycle 8-bit MIPS-style CPU: 4x8 register file, 32x8 data memory,
// external combinational instruction ROM, 7-segment and LED debug outputs.
module mips
  import mips_pkg::*;
(
  input  logic       Clk_O,
  input  logic       Reset,
  input  logic [7:0] Instruction,
  output logic [7:0] PC,
  output logic [6:0] LED,
  output logic [6:0] LEDten,
  output logic [6:0] LEDPC,
  output logic [6:0] LEDPCten,
  output logic [6:0] LEDSC,
  output logic [6:0] LEDwrr,
  output logic [3:0] LEDs
);

  logic [7:0] regs [NREGS];
  logic [7:0] dmem [DMEM_DEPTH];
  logic [7:0] pc_q;
  logic [3:0] cycle_cnt;

  instr_t     ins;
  logic [7:0] rs_val;
  logic [7:0] rt_val;
  logic [7:0] sum;
  logic [7:0] eff_addr;
  logic [DMEM_AW-1:0] mem_addr;
  logic [7:0] load_data;
  logic [7:0] pc_inc;
  logic [7:0] jump_target;
  logic [7:0] pc_next;
  logic [7:0] disp;
  logic       reg_we;
  logic [1:0] reg_waddr;
  logic [7:0] reg_wdata;
  logic       mem_we;
  logic       wrr_show;
  logic [1:0] wrr_num;
  logic [6:0] wrr_seg;

  assign ins = instr_t'(Instruction);
  assign PC  = pc_q;

  // Datapath: operand reads, address and next-PC arithmetic
  always_comb begin
    rs_val      = regs[ins.rs];
    rt_val      = regs[ins.rt];
    sum         = rs_val + rt_val;
    eff_addr    = rs_val + sext2(ins.rd);
    mem_addr    = eff_addr[DMEM_AW-1:0];
    load_data   = dmem[mem_addr];
    pc_inc      = pc_q + 8'd1;
    jump_target = pc_inc + sext6(Instruction[5:0]);
  end

  // Control decode: write enables, next PC, display value and opcode LEDs
  always_comb begin
    reg_we    = 1'b0;
    reg_waddr = ins.rd;
    reg_wdata = sum;
    mem_we    = 1'b0;
    pc_next   = pc_inc;
    disp      = sum;
    wrr_show  = 1'b0;
    wrr_num   = ins.rd;
    LEDs      = 4'b0001;
    case (ins.op)
      OP_ADD: begin
        reg_we   = 1'b1;
        wrr_show = 1'b1;
        LEDs     = 4'b0001;
      end
      OP_LW: begin
        reg_we    = 1'b1;
        reg_waddr = ins.rt;
        reg_wdata = load_data;
        disp      = load_data;
        wrr_show  = 1'b1;
        wrr_num   = ins.rt;
        LEDs      = 4'b0010;
      end
      OP_SW: begin
        mem_we = 1'b1;
        disp   = rt_val;
        LEDs   = 4'b0100;
      end
      OP_J: begin
        pc_next = jump_target;
        disp    = jump_target;
        LEDs    = 4'b1000;
      end
      default: ;
    endcase
  end

  // Architectural state update; reset reloads dmem with its own addresses
  always_ff @(posedge Clk_O) begin
    if (Reset) begin
      pc_q      <= '0;
      cycle_cnt <= '0;
      regs      <= '{default: '0};
      for (int unsigned i = 0; i < DMEM_DEPTH; i++) begin
        dmem[i[DMEM_AW-1:0]] <= 8'(i);
      end
    end else begin
      pc_q      <= pc_next;
      cycle_cnt <= cycle_cnt + 4'd1;
      if (reg_we) begin
        regs[reg_waddr] <= reg_wdata;
      end
      if (mem_we) begin
        dmem[mem_addr] <= rt_val;
      end
    end
  end

  seg7_hex u_seg_lo    (.hex(disp[3:0]),          .seg(LED));
  seg7_hex u_seg_hi    (.hex(disp[7:4]),          .seg(LEDten));
  seg7_hex u_seg_pc_lo (.hex(pc_q[3:0]),          .seg(LEDPC));
  seg7_hex u_seg_pc_hi (.hex(pc_q[7:4]),          .seg(LEDPCten));
  seg7_hex u_seg_cnt   (.hex(cycle_cnt),          .seg(LEDSC));
  seg7_hex u_seg_wrr   (.hex({2'b00, wrr_num}),   .seg(wrr_seg));

  assign LEDwrr = wrr_show ? wrr_seg : SEG_BLANK;

endmodule

// File: tb/tb_mips.sv
// Scoreboard bench for the mips CPU: a driver issues instructions, predicts every
// visible output from an architectural model, and a monitor compares each cycle.
module tb_mips;

  logic       Clk_O = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Instruction = 8'h00;
  logic [7:0] PC;
  logic [6:0] LED, LEDten, LEDPC, LEDPCten, LEDSC, LEDwrr;
  logic [3:0] LEDs;

  mips dut (
    .Clk_O(Clk_O), .Reset(Reset), .Instruction(Instruction), .PC(PC),
    .LED(LED), .LEDten(LEDten), .LEDPC(LEDPC), .LEDPCten(LEDPCten),
    .LEDSC(LEDSC), .LEDwrr(LEDwrr), .LEDs(LEDs)
  );

  always #5 Clk_O = ~Clk_O;

  typedef struct {
    bit known;
    int pc, led, ledten, ledpc, ledpcten, ledsc, ledwrr, leds;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Architectural model state
  int  m_regs[4];
  int  m_dmem[32];
  int  m_pc = 0;
  int  m_cnt = 0;
  bit  m_known = 1'b0;

  // Lit segments for each hex glyph
  string on_segs[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic int seg(input int v);
    string s;
    logic [6:0] p;
    s = on_segs[v & 15];
    p = 7'h7F;
    for (int i = 0; i < s.len(); i++) p[int'(s[i]) - 97] = 1'b0;
    return int'(p);
  endfunction

  function automatic int simm(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // One cycle of stimulus: predict outputs from the current state, then advance the model
  task automatic step(input bit rst, input logic [7:0] ins);
    exp_t e;
    int op, rs, rt, rd, addr, val, tgt;
    @(posedge Clk_O);
    #1;
    Reset = rst;
    Instruction = ins;
    op = int'(ins[7:6]); rs = int'(ins[5:4]); rt = int'(ins[3:2]); rd = int'(ins[1:0]);
    addr = (m_regs[rs] + simm(rd, 2)) & 31;
    tgt  = (m_pc + 1 + simm(int'(ins[5:0]), 6)) & 255;
    case (op)
      0: val = (m_regs[rs] + m_regs[rt]) % 256;
      1: val = m_dmem[addr];
      2: val = m_regs[rt];
      default: val = tgt;
    endcase
    e.known    = m_known;
    e.pc       = m_pc;
    e.led      = seg(val % 16);
    e.ledten   = seg(val / 16);
    e.ledpc    = seg(m_pc % 16);
    e.ledpcten = seg(m_pc / 16);
    e.ledsc    = seg(m_cnt);
    e.ledwrr   = (op == 0) ? seg(rd) : (op == 1) ? seg(rt) : 'h7F;
    e.leds     = 1 << op;
    q.push_back(e);
    if (rst) begin
      m_pc = 0; m_cnt = 0; m_known = 1'b1;
      foreach (m_regs[i]) m_regs[i] = 0;
      foreach (m_dmem[i]) m_dmem[i] = i;
    end else begin
      m_cnt = (m_cnt + 1) % 16;
      m_pc  = (op == 3) ? tgt : (m_pc + 1) % 256;
      if (op == 0) m_regs[rd] = val;
      if (op == 1) m_regs[rt] = val;
      if (op == 2) m_dmem[addr] = val;
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk_O);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.known) begin
          chk("pc",       int'(PC),       e.pc);
          chk("led",      int'(LED),      e.led);
          chk("ledten",   int'(LEDten),   e.ledten);
          chk("ledpc",    int'(LEDPC),    e.ledpc);
          chk("ledpcten", int'(LEDPCten), e.ledpcten);
          chk("ledsc",    int'(LEDSC),    e.ledsc);
          chk("ledwrr",   int'(LEDwrr),   e.ledwrr);
          chk("leds",     int'(LEDs),     e.leds);
        end
      end
    end
  end

  // Driver: directed program, then random instructions with occasional reset
  initial begin
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    step(1'b0, 8'b01_00_01_01);   // lw r1,1(r0)
    step(1'b0, 8'b00_01_01_10);   // add r2,r1,r1
    step(1'b0, 8'b10_00_10_11);   // sw r2,-1(r0)
    step(1'b0, 8'b01_00_11_11);   // lw r3,-1(r0)
    step(1'b0, 8'b00_00_00_00);   // add r0,r0,r0 -> PC=5
    step(1'b0, 8'b11_111111);     // j -1 stays at 5
    step(1'b0, 8'b11_111111);
    step(1'b0, 8'b11_111001);     // j -7 -> PC=FF
    step(1'b0, 8'b00_01_10_00);   // add at FF wraps to 00
    step(1'b0, 8'b01_11_01_00);   // lw r1,0(r3)
    step(1'b0, 8'b10_00_01_10);   // sw r1,-2(r0)
    step(1'b1, 8'b10_00_10_00);   // reset aborts a store
    step(1'b0, 8'b01_00_10_00);   // lw r2,0(r0)
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, 8'($urandom));
    end
    @(negedge Clk_O);
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
